// File: rtl/text_mode_renderer.sv
// rtl/text_mode_renderer.sv - 32x30 character-cell text renderer with a 3-cycle pixel pipeline
// Optional per-cell colour attributes are compiled in with `define COLOR_ATTR_EN.
module text_mode_renderer #(
    parameter int         DATA_WIDTH = 10,
    parameter int         COLS       = 32,
    parameter int         ROWS       = 30,
    parameter int         ADDR_WIDTH = 10,
    parameter logic [2:0] FG_COLOR   = 3'b111,
    parameter logic [2:0] BG_COLOR   = 3'b000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] hpos,
    input  logic [DATA_WIDTH-1:0] vpos,
    input  logic                  display_on,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    output logic [ADDR_WIDTH-1:0] vram_addr,
    output logic                  vram_rd,
`ifdef COLOR_ATTR_EN
    input  logic [13:0]           vram_data,
`else
    input  logic [7:0]            vram_data,
`endif
    output logic [10:0]           font_addr,
    input  logic [7:0]            font_data,
    output logic [2:0]            rgb,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  display_on_out
);

    localparam int VIS_LINES = ROWS * 8;
    localparam int COL_SHIFT = $clog2(COLS);
    localparam bit COLS_POW2 = (COLS == (1 << COL_SHIFT));

    logic                  row_vis;
    logic                  fetch;
    logic [ADDR_WIDTH-1:0] row_base;
    logic [ADDR_WIDTH-1:0] cell_addr;
    logic [ADDR_WIDTH-1:0] vram_addr_q;
    logic [10:0]           font_addr_q;
    logic                  fetch_d1_q;
    logic [2:0]            vrow_d1_q;
    logic [2:0]            hcol_d1_q, hcol_d2_q;
    logic                  vis_d1_q, vis_d2_q;
    logic [2:0]            hs_q, vs_q, de_q;
    logic [7:0]            shifter_q, shifter_d;
    logic [2:0]            rgb_q, rgb_d;
    logic [2:0]            fg_d, bg_d;
    logic                  cell_start;

    assign row_vis = (vpos < DATA_WIDTH'(VIS_LINES));
    // Reset is folded in so the strobe drops the instant reset_n falls.
    assign fetch   = reset_n && display_on && (hpos[2:0] == 3'd0) && row_vis;

    generate
        if (COLS_POW2) begin : g_row_shift
            assign row_base = ADDR_WIDTH'(vpos >> 3) << COL_SHIFT;
        end else begin : g_row_mul
            assign row_base = ADDR_WIDTH'(vpos >> 3) * ADDR_WIDTH'(COLS);
        end
    endgenerate

    assign cell_addr = row_base + ADDR_WIDTH'(hpos >> 3);
    assign vram_addr = fetch ? cell_addr : vram_addr_q;
    assign vram_rd   = fetch;

    // Font row comes from stage-1 vpos so a line change cannot mix glyph rows.
    assign font_addr = fetch_d1_q ? {vram_data[7:0], vrow_d1_q} : font_addr_q;

    assign cell_start = (hcol_d2_q == 3'd0);
    assign shifter_d  = cell_start ? font_data : {shifter_q[6:0], 1'b0};

`ifdef COLOR_ATTR_EN
    logic [2:0] fg_d2_q, bg_d2_q, fg_q, bg_q;

    assign fg_d = cell_start ? fg_d2_q : fg_q;
    assign bg_d = cell_start ? bg_d2_q : bg_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fg_d2_q <= 3'd0;
            bg_d2_q <= 3'd0;
            fg_q    <= 3'd0;
            bg_q    <= 3'd0;
        end else begin
            if (fetch_d1_q) begin
                fg_d2_q <= vram_data[10:8];
                bg_d2_q <= vram_data[13:11];
            end
            fg_q <= fg_d;
            bg_q <= bg_d;
        end
    end
`else
    assign fg_d = FG_COLOR;
    assign bg_d = BG_COLOR;
`endif

    always_comb begin
        rgb_d = 3'd0;
        if (de_q[1]) begin
            if (!vis_d2_q)
                rgb_d = bg_d;
            else
                rgb_d = shifter_d[7] ? fg_d : bg_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vram_addr_q <= '0;
            font_addr_q <= 11'd0;
            fetch_d1_q  <= 1'b0;
            vrow_d1_q   <= 3'd0;
            hcol_d1_q   <= 3'd0;
            hcol_d2_q   <= 3'd0;
            vis_d1_q    <= 1'b0;
            vis_d2_q    <= 1'b0;
            hs_q        <= 3'b111;
            vs_q        <= 3'b111;
            de_q        <= 3'b000;
            shifter_q   <= 8'd0;
            rgb_q       <= 3'd0;
        end else begin
            vram_addr_q <= vram_addr;
            font_addr_q <= font_addr;
            fetch_d1_q  <= fetch;
            vrow_d1_q   <= vpos[2:0];
            hcol_d1_q   <= hpos[2:0];
            hcol_d2_q   <= hcol_d1_q;
            vis_d1_q    <= row_vis;
            vis_d2_q    <= vis_d1_q;
            hs_q        <= {hs_q[1:0], hsync_in};
            vs_q        <= {vs_q[1:0], vsync_in};
            de_q        <= {de_q[1:0], display_on};
            shifter_q   <= shifter_d;
            rgb_q       <= rgb_d;
        end
    end

    assign rgb            = rgb_q;
    assign hsync_out      = hs_q[2];
    assign vsync_out      = vs_q[2];
    assign display_on_out = de_q[2];

endmodule

// File: tb/tb_text_mode_renderer.sv
// tb/tb_text_mode_renderer.sv - randomized scan bench for text_mode_renderer against a pixel-rule model
module tb_text_mode_renderer;

`ifdef COLOR_ATTR_EN
    localparam int VW = 14;
`else
    localparam int VW = 8;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [9:0]    hpos, vpos;
    logic          display_on, hsync_in, vsync_in;
    logic [9:0]    vram_addr;
    logic          vram_rd;
    logic [VW-1:0] vram_data;
    logic [10:0]   font_addr;
    logic [7:0]    font_data;
    logic [2:0]    rgb;
    logic          hsync_out, vsync_out, display_on_out;

    always #5 clk = ~clk;

    text_mode_renderer dut (
        .clk(clk), .reset_n(reset_n), .hpos(hpos), .vpos(vpos),
        .display_on(display_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_data(vram_data),
        .font_addr(font_addr), .font_data(font_data), .rgb(rgb),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .display_on_out(display_on_out)
    );

    logic [VW-1:0] vram_mem [0:959];
    logic [7:0]    font_mem [0:2047];

    initial begin
        vram_data = '0;
        font_data = 8'd0;
    end

    always @(posedge clk) begin
        if (vram_rd) vram_data <= vram_mem[vram_addr];
        font_data <= font_mem[font_addr];
    end

    typedef struct {
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
        logic       de;
        logic       chk;
    } exp_t;

    exp_t pipe[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   skip_rgb = 0;
    bit   prev_fetch = 0;
    int   prev_cell = 0;
    int   prev_v = 0;
    int   rd_count = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] model_pixel(input int h, input int v, input bit de);
        logic [VW-1:0] w;
        logic [7:0]    bits;
        logic [2:0]    fg, bg;
        int            row;
        if (!de || v >= 240) return 3'd0;
        w   = vram_mem[(v / 8) * 32 + (h / 8)];
        row = v % 8;
        bits = font_mem[{w[7:0], 3'(row)}];
`ifdef COLOR_ATTR_EN
        fg = w[10:8];
        bg = w[13:11];
`else
        fg = 3'b111;
        bg = 3'b000;
`endif
        return bits[7 - (h % 8)] ? fg : bg;
    endfunction

    task automatic preload_reset_pipe();
        exp_t e;
        pipe.delete();
        e = '{rgb: 3'd0, hs: 1'b1, vs: 1'b1, de: 1'b0, chk: 1'b1};
        repeat (3) pipe.push_back(e);
    endtask

    task automatic cycle(input int h, input int v);
        exp_t       e;
        bit         de, fetch;
        logic [10:0] fa;
        logic [VW-1:0] w;
        de = (h < 256) && (v < 240);
        hpos       = 10'(h);
        vpos       = 10'(v);
        display_on = de;
        hsync_in   = !(h >= 270 && h < 280);
        vsync_in   = !(v >= 245 && v < 248);
        if (h % 8 == 0) skip_rgb = 0;
        e = '{rgb: model_pixel(h, v, de), hs: hsync_in, vs: vsync_in, de: de, chk: !skip_rgb};
        pipe.push_back(e);
        fetch = de && (h % 8 == 0);
        @(negedge clk);
        check_val("vram_rd", vram_rd, fetch);
        if (fetch) begin
            rd_count++;
            check_val("vram_addr", vram_addr, (v / 8) * 32 + h / 8);
        end
        if (prev_fetch) begin
            w  = vram_mem[prev_cell];
            fa = {w[7:0], 3'(prev_v % 8)};
            check_val("font_addr", font_addr, fa);
        end
        e = pipe.pop_front();
        if (e.chk) check_val("rgb", rgb, e.rgb);
        check_val("hsync_out", hsync_out, e.hs);
        check_val("vsync_out", vsync_out, e.vs);
        check_val("display_on_out", display_on_out, e.de);
        prev_fetch = fetch;
        prev_cell  = (v / 8) * 32 + h / 8;
        prev_v     = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_val("rst_rgb", rgb, 0);
        check_val("rst_hsync", hsync_out, 1);
        check_val("rst_vsync", vsync_out, 1);
        check_val("rst_de", display_on_out, 0);
        check_val("rst_vram_rd", vram_rd, 0);
        check_val("rst_vram_addr", vram_addr, 0);
        check_val("rst_font_addr", font_addr, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n    = 1'b1;
        skip_rgb   = 1;
        prev_fetch = 0;
        preload_reset_pipe();
    endtask

    initial begin
        int lines[$];
        logic [VW-1:0] a_cell;
        reset_n    = 1'b1;
        hpos       = 10'd0;
        vpos       = 10'd0;
        display_on = 1'b0;
        hsync_in   = 1'b1;
        vsync_in   = 1'b1;
        for (int i = 0; i < 960; i++) vram_mem[i] = VW'($urandom);
        for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom);
`ifdef COLOR_ATTR_EN
        a_cell = 14'b001_010_01000001;
`else
        a_cell = 8'h41;
`endif
        vram_mem[0] = a_cell;
        font_mem[11'h41 << 3] = 8'b10100000;

        @(posedge clk);
        #1;
        do_reset();

        lines = '{0, 9, 239, 240, 250, 261};
        repeat (5) lines.push_back($urandom_range(0, 261));

        foreach (lines[li]) begin
            bit had_reset;
            had_reset = 0;
            rd_count  = 0;
            for (int h = 0; h < 300; h++) begin
                if (li == 2 && h == 100) begin
                    do_reset();
                    had_reset = 1;
                end
                cycle(h, lines[li]);
            end
            if (!had_reset)
                check_val("rd_per_line", rd_count, (lines[li] < 240) ? 32 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
